// File: rtl/audio_nios_pll_supervisor_pkg.sv
// -----------------------------------------------------------------------------
// audio_nios_pll_pkg
// Shared definitions for the audio PLL supervisor:
//   - state_t   : FSM state encoding, also exported on the status port
//   - drive_t   : the three per-state control outputs
//   - drive_for : maps a state to its control outputs, so every transition
//                 loads outputs that match the state it enters
// -----------------------------------------------------------------------------
package audio_nios_pll_pkg;

  localparam int STATE_W    = 3;
  localparam int LOSS_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_SETTLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  typedef struct packed {
    logic pll_rst;
    logic audio_ready;
    logic fault;
  } drive_t;

  function automatic drive_t drive_for(state_t s);
    drive_t d;
    d = '{pll_rst: 1'b0, audio_ready: 1'b0, fault: 1'b0};
    case (s)
      S_RESET_PLL: d.pll_rst = 1'b1;
      S_RUN:       d.audio_ready = 1'b1;
      S_FAULT:     begin
        d.pll_rst = 1'b1;
        d.fault   = 1'b1;
      end
      default:     ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/audio_nios_pll_supervisor_if.sv
// -----------------------------------------------------------------------------
// audio_nios_pll_supervisor_if
// Bundles the supervisor's PLL, CSR and status signals.
//   master : the supervisor (drives PLL reset, ready, fault and status)
//   slave  : the surroundings (PLL lock output and CSR restart request)
// Signals:
//   pll_locked      PLL lock output, asynchronous to refclk
//   sw_restart      single-cycle restart request
//   pll_rst         PLL reset
//   audio_ready     audio datapath reset release (high only in RUN)
//   fault           high only in FAULT
//   state           current state encoding
//   retry_count     failed lock attempts since last RUN or restart
//   lock_loss_count saturating count of lock losses seen in RUN
// -----------------------------------------------------------------------------
interface audio_nios_pll_supervisor_if;
  import audio_nios_pll_pkg::*;

  logic                  pll_locked;
  logic                  sw_restart;
  logic                  pll_rst;
  logic                  audio_ready;
  logic                  fault;
  state_t                state;
  logic [3:0]            retry_count;
  logic [LOSS_CNT_W-1:0] lock_loss_count;

  modport master (
    input  pll_locked, sw_restart,
    output pll_rst, audio_ready, fault, state, retry_count, lock_loss_count
  );

  modport slave (
    output pll_locked, sw_restart,
    input  pll_rst, audio_ready, fault, state, retry_count, lock_loss_count
  );

endinterface

// File: rtl/audio_nios_pll_supervisor_bit_sync.sv
// -----------------------------------------------------------------------------
// audio_nios_bit_sync
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Ports:
//   clk   destination clock
//   rst_n synchronous active-low reset, clears both flops to 0
//   d     asynchronous input
//   q     synchronized output, two clk edges of latency
// -----------------------------------------------------------------------------
module audio_nios_bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make both flops sample on the same edge;
  // blocking here would collapse the chain into a single stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/audio_nios_pll_supervisor.sv
// -----------------------------------------------------------------------------
// audio_nios_pll_supervisor
// Sequences the audio PLL from the free-running refclk: holds the PLL in
// reset, waits for lock, requires lock to stay stable, then releases the
// audio datapath. Lock loss in RUN re-sequences; repeated lock timeouts park
// the block in FAULT until software requests a restart.
// Ports:
//   refclk  sole clock (board reference, runs while the PLL output is absent)
//   rst_n   synchronous active-low reset
//   bus     master side of audio_nios_pll_supervisor_if
// Parameters:
//   RST_CYCLES     cycles pll_rst is held per attempt (>= 2)
//   LOCK_TIMEOUT   cycles allowed in WAIT_LOCK before the attempt fails
//   SETTLE_CYCLES  consecutive locked cycles required before RUN
//   MAX_RETRIES    failed attempts before FAULT (1..15)
// -----------------------------------------------------------------------------
module audio_nios_pll_supervisor
  import audio_nios_pll_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                        refclk,
  input  logic                        rst_n,
  audio_nios_pll_supervisor_if.master bus
);

  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
  localparam int TW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

  state_t                state_q;
  drive_t                drv_q;
  logic [TW-1:0]         timer;
  logic [3:0]            retry_q;
  logic [LOSS_CNT_W-1:0] loss_q;
  logic                  locked_s;
  logic [3:0]            retry_inc;

  audio_nios_bit_sync u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (bus.pll_locked),
    .q     (locked_s)
  );

  assign retry_inc = retry_q + 4'd1;

  // Every transition loads drive_for(next state) into drv_q on the same edge
  // as state_q, so outputs are registered and never lag the state.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q <= S_RESET_PLL;
      drv_q   <= '{pll_rst: 1'b1, audio_ready: 1'b0, fault: 1'b0};
      timer   <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else if (bus.sw_restart) begin
      // Restart wins over every FSM transition, including a lock drop in RUN.
      state_q <= S_RESET_PLL;
      drv_q   <= drive_for(S_RESET_PLL);
      timer   <= '0;
      retry_q <= '0;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (timer == RST_LAST) begin
            state_q <= S_WAIT_LOCK;
            drv_q   <= drive_for(S_WAIT_LOCK);
            timer   <= '0;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end

        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_q <= S_SETTLE;
            drv_q   <= drive_for(S_SETTLE);
            timer   <= '0;
          end else if (timer == LOCK_LAST) begin
            retry_q <= retry_inc;
            timer   <= '0;
            if (retry_inc == RETRY_LIMIT) begin
              state_q <= S_FAULT;
              drv_q   <= drive_for(S_FAULT);
            end else begin
              state_q <= S_RESET_PLL;
              drv_q   <= drive_for(S_RESET_PLL);
            end
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end

        S_SETTLE: begin
          if (!locked_s) begin
            // Glitch: start the lock wait over, but it is not a failed attempt.
            state_q <= S_WAIT_LOCK;
            drv_q   <= drive_for(S_WAIT_LOCK);
            timer   <= '0;
          end else if (timer == SETTLE_LAST) begin
            state_q <= S_RUN;
            drv_q   <= drive_for(S_RUN);
            timer   <= '0;
            retry_q <= '0;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end

        S_RUN: begin
          // Timer idles at 0 here; it was cleared on entry.
          if (!locked_s) begin
            state_q <= S_RESET_PLL;
            drv_q   <= drive_for(S_RESET_PLL);
            timer   <= '0;
            if (loss_q != '1) loss_q <= loss_q + LOSS_CNT_W'(1);
          end
        end

        S_FAULT: begin
          // Parked until sw_restart or rst_n.
        end

        // NOTE: the default arm gives a defined next state for encodings 5-7
        // and keeps the case complete, so nothing is left to hold implicitly.
        default: begin
          state_q <= S_RESET_PLL;
          drv_q   <= drive_for(S_RESET_PLL);
          timer   <= '0;
        end
      endcase
    end
  end

  assign bus.state           = state_q;
  assign bus.pll_rst         = drv_q.pll_rst;
  assign bus.audio_ready     = drv_q.audio_ready;
  assign bus.fault           = drv_q.fault;
  assign bus.retry_count     = retry_q;
  assign bus.lock_loss_count = loss_q;

endmodule

// File: tb/tb_audio_nios_pll_supervisor.sv
// -----------------------------------------------------------------------------
// tb_audio_nios_pll_supervisor
// Directed bench for audio_nios_pll_supervisor with RST_CYCLES=4,
// LOCK_TIMEOUT=20, SETTLE_CYCLES=8, MAX_RETRIES=2. Inputs change 1 ns after
// a rising edge and outputs are sampled at the same point, so each step()
// covers exactly one DUT edge.
// -----------------------------------------------------------------------------
module tb_audio_nios_pll_supervisor;
  import audio_nios_pll_pkg::*;

  logic refclk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  audio_nios_pll_supervisor_if bus ();

  audio_nios_pll_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .SETTLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 refclk = ~refclk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Bounded wait for a state; n returns edges taken. Missing the target
  // within budget shows up as a failed comparison.
  task automatic wait_state(input string tag, input state_t target,
                            input int budget, output int n);
    n = 0;
    while (bus.state !== target && n < budget) begin
      step();
      n++;
    end
    check(tag, int'(bus.state), int'(target));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, int'(bus.state), int'(S_RESET_PLL));
    check({tag, "_pll_rst"}, int'(bus.pll_rst), 1);
    check({tag, "_ready"}, int'(bus.audio_ready), 0);
    check({tag, "_fault"}, int'(bus.fault), 0);
    check({tag, "_retry"}, int'(bus.retry_count), 0);
    check({tag, "_loss"}, int'(bus.lock_loss_count), 0);
  endtask

  initial begin
    int n;
    int bad;

    rst_n          = 1'b0;
    bus.pll_locked = 1'b0;
    bus.sw_restart = 1'b0;
    steps(2);
    check_reset_values("por");

    // 1: clean bring-up, lock arrives at cycle 10.
    rst_n = 1'b1;
    steps(3);
    check("t1_rst_hold", int'(bus.pll_rst), 1);
    check("t1_rst_state", int'(bus.state), int'(S_RESET_PLL));
    step();
    check("t1_rst_release", int'(bus.pll_rst), 0);
    check("t1_wait_lock", int'(bus.state), int'(S_WAIT_LOCK));
    steps(6);
    bus.pll_locked = 1'b1;
    steps(2);
    check("t1_sync_latency", int'(bus.state), int'(S_WAIT_LOCK));
    step();
    check("t1_settle_entry", int'(bus.state), int'(S_SETTLE));
    steps(7);
    check("t1_settle_last", int'(bus.state), int'(S_SETTLE));
    check("t1_not_ready", int'(bus.audio_ready), 0);
    step();
    check("t1_run", int'(bus.state), int'(S_RUN));
    check("t1_ready", int'(bus.audio_ready), 1);
    check("t1_retry", int'(bus.retry_count), 0);

    // 3: one-cycle lock drop in RUN.
    bus.pll_locked = 1'b0;
    step();
    bus.pll_locked = 1'b1;
    step();
    check("t3_ready_edge2", int'(bus.audio_ready), 1);
    step();
    check("t3_ready_edge3", int'(bus.audio_ready), 0);
    check("t3_reseq_state", int'(bus.state), int'(S_RESET_PLL));
    check("t3_pll_rst", int'(bus.pll_rst), 1);
    check("t3_loss", int'(bus.lock_loss_count), 1);
    wait_state("t3_back_to_run", S_RUN, 40, n);
    check("t3_reseq_edges", n, 13);

    // 4: one failed attempt, then a lock glitch during SETTLE.
    bus.sw_restart = 1'b1;
    bus.pll_locked = 1'b0;
    step();
    bus.sw_restart = 1'b0;
    check("t4_restart_state", int'(bus.state), int'(S_RESET_PLL));
    n = 0;
    while (bus.retry_count !== 4'd1 && n < 40) begin
      step();
      n++;
    end
    check("t4_timeout_edges", n, 24);
    check("t4_timeout_state", int'(bus.state), int'(S_RESET_PLL));
    bus.pll_locked = 1'b1;
    wait_state("t4_settle", S_SETTLE, 20, n);
    steps(4);
    bus.pll_locked = 1'b0;
    step();
    bus.pll_locked = 1'b1;
    steps(2);
    check("t4_glitch_back", int'(bus.state), int'(S_WAIT_LOCK));
    check("t4_retry_kept", int'(bus.retry_count), 1);
    step();
    check("t4_resettle", int'(bus.state), int'(S_SETTLE));
    steps(7);
    check("t4_still_settle", int'(bus.state), int'(S_SETTLE));
    step();
    check("t4_run", int'(bus.state), int'(S_RUN));
    check("t4_retry_cleared", int'(bus.retry_count), 0);

    // 5a: restart coinciding with a lock drop seen in RUN.
    bus.pll_locked = 1'b0;
    steps(2);
    bus.sw_restart = 1'b1;
    step();
    bus.sw_restart = 1'b0;
    check("t5_coincide_state", int'(bus.state), int'(S_RESET_PLL));
    check("t5_coincide_loss", int'(bus.lock_loss_count), 1);

    // 2: lock never arrives -> two timeouts -> FAULT.
    steps(4);
    check("t2_wait1", int'(bus.state), int'(S_WAIT_LOCK));
    steps(19);
    check("t2_wait1_end", int'(bus.state), int'(S_WAIT_LOCK));
    step();
    check("t2_retry1_state", int'(bus.state), int'(S_RESET_PLL));
    check("t2_retry1", int'(bus.retry_count), 1);
    steps(3);
    check("t2_rst_pulse", int'(bus.pll_rst), 1);
    step();
    check("t2_wait2", int'(bus.state), int'(S_WAIT_LOCK));
    steps(19);
    check("t2_wait2_end", int'(bus.state), int'(S_WAIT_LOCK));
    step();
    check("t2_fault_state", int'(bus.state), int'(S_FAULT));
    check("t2_fault", int'(bus.fault), 1);
    check("t2_fault_rst", int'(bus.pll_rst), 1);
    check("t2_retry2", int'(bus.retry_count), 2);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.state !== S_FAULT || bus.pll_rst !== 1'b1 || bus.fault !== 1'b1) bad++;
    end
    check("t2_fault_hold", bad, 0);
    bus.sw_restart = 1'b1;
    step();
    bus.sw_restart = 1'b0;
    check("t2_restart_state", int'(bus.state), int'(S_RESET_PLL));
    check("t2_restart_fault", int'(bus.fault), 0);
    check("t2_restart_retry", int'(bus.retry_count), 0);

    // 5: 259 further lock losses; 1 + 259 saturates at 255.
    bus.pll_locked = 1'b1;
    wait_state("t5_run", S_RUN, 40, n);
    for (int i = 0; i < 259; i++) begin
      bus.pll_locked = 1'b0;
      step();
      bus.pll_locked = 1'b1;
      wait_state("t5_loss_reseq", S_RESET_PLL, 5, n);
      if (i == 252) check("t5_loss_254", int'(bus.lock_loss_count), 254);
      wait_state("t5_loss_run", S_RUN, 40, n);
    end
    check("t5_loss_sat", int'(bus.lock_loss_count), 255);

    // 6: rst_n mid-SETTLE and mid-FAULT (the latter with sw_restart too).
    bus.sw_restart = 1'b1;
    step();
    bus.sw_restart = 1'b0;
    wait_state("t6_settle", S_SETTLE, 20, n);
    steps(2);
    rst_n = 1'b0;
    step();
    check_reset_values("t6_settle_rst");
    rst_n          = 1'b1;
    bus.pll_locked = 1'b0;
    wait_state("t6_fault", S_FAULT, 80, n);
    check("t6_fault_flag", int'(bus.fault), 1);
    rst_n          = 1'b0;
    bus.sw_restart = 1'b1;
    step();
    check_reset_values("t6_fault_rst");
    bus.sw_restart = 1'b0;
    rst_n          = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
